store_trace_sink: RTL and testbench

//  Consumer end of the core's store-trace port (DONE/OUTADDR/OUTDATA/OUTVALID).
//  - Captures every store into a shadow copy of data memory and counts writes.
//  - When the core raises DONE, streams the final contents of every written word out over a valid/ready dump port.
//  - Sits beside the core in the top level; the dump port feeds the bench scoreboard or a UART bridge.

---
 rtl/store_trace_pkg.sv | 15 +
 rtl/shadow_ram.sv | 22 ++
 rtl/store_trace_sink.sv | 125 ++++++++++++
 tb/tb_store_trace_sink.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_trace_pkg.sv
// Shared defaults and FSM state type for the store-trace sink.
package store_trace_pkg;

  localparam int STP_AW    = 5;
  localparam int STP_DW    = 32;
  localparam int STP_CNT_W = 8;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    SCAN    = 2'd1,
    HOLD    = 2'd2,
    FIN     = 2'd3
  } state_e;

endpackage

// File: rtl/shadow_ram.sv
// Shadow copy of core data memory: one synchronous write port, one asynchronous read port.
module shadow_ram #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          CK,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];

  always_ff @(posedge CK) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/store_trace_sink.sv
// Captures core stores into a shadow memory, then streams every written word out on DONE.
//   state   | meaning
//   CAPTURE | accepting stores, waiting for DONE
//   SCAN    | examining one index per cycle for a written word
//   HOLD    | dump beat presented, waiting for DUMP_READY
//   FIN     | dump complete, idle until RESET
module store_trace_sink
  import store_trace_pkg::*;
#(
  parameter int AW    = STP_AW,
  parameter int DW    = STP_DW,
  parameter int CNT_W = STP_CNT_W
) (
  input  logic             CK,
  input  logic             RESET,
  input  logic             DONE,
  input  logic [AW-1:0]    OUTADDR,
  input  logic [DW-1:0]    OUTDATA,
  input  logic             OUTVALID,
  input  logic             DUMP_READY,
  output logic             DUMP_VALID,
  output logic [AW-1:0]    DUMP_ADDR,
  output logic [DW-1:0]    DUMP_DATA,
  output logic             FINISHED,
  output logic [CNT_W-1:0] WR_COUNT,
  output logic [CNT_W-1:0] OVERWRITE_COUNT,
  output logic [CNT_W-1:0] LATE_COUNT
);

  state_e             state_q;
  logic [AW-1:0]      idx_q;
  logic [2**AW-1:0]   written_q;
  logic               dump_valid_q;
  logic [AW-1:0]      dump_addr_q;
  logic [DW-1:0]      dump_data_q;
  logic               finished_q;
  logic [CNT_W-1:0]   wr_count_q;
  logic [CNT_W-1:0]   overwrite_count_q;
  logic [CNT_W-1:0]   late_count_q;

  logic               ram_we;
  logic [DW-1:0]      ram_rdata;

  // Shadow data survives reset; only the written bits decide what gets dumped.
  assign ram_we = OUTVALID && !RESET && (state_q == CAPTURE);

  shadow_ram #(.AW(AW), .DW(DW)) u_shadow_ram (
    .CK      (CK),
    .we_i    (ram_we),
    .waddr_i (OUTADDR),
    .wdata_i (OUTDATA),
    .raddr_i (idx_q),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge CK) begin
    if (RESET) begin
      state_q           <= CAPTURE;
      idx_q             <= '0;
      written_q         <= '0;
      dump_valid_q      <= 1'b0;
      dump_addr_q       <= '0;
      dump_data_q       <= '0;
      finished_q        <= 1'b0;
      wr_count_q        <= '0;
      overwrite_count_q <= '0;
      late_count_q      <= '0;
    end else begin
      case (state_q)
        CAPTURE: begin
          if (OUTVALID) begin
            written_q[OUTADDR] <= 1'b1;
            if (wr_count_q != '1) wr_count_q <= wr_count_q + 1'b1;
            if (written_q[OUTADDR] && overwrite_count_q != '1)
              overwrite_count_q <= overwrite_count_q + 1'b1;
          end
          if (DONE) begin
            state_q <= SCAN;
            idx_q   <= '0;
          end
        end
        SCAN: begin
          if (written_q[idx_q]) begin
            dump_valid_q <= 1'b1;
            dump_addr_q  <= idx_q;
            dump_data_q  <= ram_rdata;
            state_q      <= HOLD;
          end else if (idx_q == '1) begin
            state_q <= FIN;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        HOLD: begin
          if (DUMP_READY) begin
            dump_valid_q <= 1'b0;
            if (idx_q == '1) begin
              state_q <= FIN;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= SCAN;
            end
          end
        end
        FIN: begin
          finished_q   <= 1'b1;
          dump_valid_q <= 1'b0;
        end
        default: state_q <= CAPTURE;
      endcase

      if (OUTVALID && state_q != CAPTURE && late_count_q != '1)
        late_count_q <= late_count_q + 1'b1;
    end
  end

  assign DUMP_VALID      = dump_valid_q;
  assign DUMP_ADDR       = dump_addr_q;
  assign DUMP_DATA       = dump_data_q;
  assign FINISHED        = finished_q;
  assign WR_COUNT        = wr_count_q;
  assign OVERWRITE_COUNT = overwrite_count_q;
  assign LATE_COUNT      = late_count_q;

endmodule

// File: tb/tb_store_trace_sink.sv
// Bench for store_trace_sink: directed runs checked against a memory/queue model of the trace.
module tb_store_trace_sink;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = 8;
  localparam int DEPTH = 2**AW;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } beat_t;

  logic          CK = 1'b0;
  logic          RESET = 1'b1;
  logic          DONE = 1'b0;
  logic [AW-1:0] OUTADDR = '0;
  logic [DW-1:0] OUTDATA = '0;
  logic          OUTVALID = 1'b0;
  logic          DUMP_READY = 1'b0;
  logic          DUMP_VALID;
  logic [AW-1:0] DUMP_ADDR;
  logic [DW-1:0] DUMP_DATA;
  logic          FINISHED;
  logic [CW-1:0] WR_COUNT;
  logic [CW-1:0] OVERWRITE_COUNT;
  logic [CW-1:0] LATE_COUNT;

  store_trace_sink #(.AW(AW), .DW(DW), .CNT_W(CW)) dut (
    .CK              (CK),
    .RESET           (RESET),
    .DONE            (DONE),
    .OUTADDR         (OUTADDR),
    .OUTDATA         (OUTDATA),
    .OUTVALID        (OUTVALID),
    .DUMP_READY      (DUMP_READY),
    .DUMP_VALID      (DUMP_VALID),
    .DUMP_ADDR       (DUMP_ADDR),
    .DUMP_DATA       (DUMP_DATA),
    .FINISHED        (FINISHED),
    .WR_COUNT        (WR_COUNT),
    .OVERWRITE_COUNT (OVERWRITE_COUNT),
    .LATE_COUNT      (LATE_COUNT)
  );

  always #5 CK = ~CK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: memory image + written flags; at close the dump is every written address in order.
  bit            m_wr [DEPTH];
  logic [DW-1:0] m_sh [DEPTH];
  bit            m_open = 1'b1;
  bit            m_armed = 1'b0;
  bit            m_last_rst = 1'b0;
  int            m_wrc = 0, m_owc = 0, m_late = 0;
  beat_t         m_exp[$];
  beat_t         log_q[$];

  initial forever begin
    @(posedge CK);
    m_last_rst = RESET;
    if (RESET) begin
      m_armed = 1'b1;
      m_open  = 1'b1;
      for (int i = 0; i < DEPTH; i++) m_wr[i] = 1'b0;
      m_wrc = 0; m_owc = 0; m_late = 0;
      m_exp.delete();
    end else if (m_open) begin
      if (OUTVALID) begin
        if (m_wrc < 255) m_wrc++;
        if (m_wr[OUTADDR] && m_owc < 255) m_owc++;
        m_wr[OUTADDR] = 1'b1;
        m_sh[OUTADDR] = OUTDATA;
      end
      if (DONE) begin
        m_open = 1'b0;
        for (int i = 0; i < DEPTH; i++)
          if (m_wr[i]) m_exp.push_back('{a: AW'(i), d: m_sh[i]});
      end
    end else if (OUTVALID) begin
      if (m_late < 255) m_late++;
    end
  end

  // Per-cycle compare, sampled on the falling edge.
  bit    prev_hold = 1'b0;
  beat_t prev_beat;
  bit    fin_prev = 1'b0;

  initial forever begin
    @(negedge CK);
    if (m_armed) begin
      check("wr_count", WR_COUNT, m_wrc);
      check("overwrite_count", OVERWRITE_COUNT, m_owc);
      check("late_count", LATE_COUNT, m_late);
      if (m_last_rst) begin
        prev_hold = 1'b0;
      end else begin
        check("no_beat_in_capture", DUMP_VALID && m_open, 0);
        check("no_beat_when_finished", DUMP_VALID && FINISHED, 0);
        if (prev_hold) begin
          check("hold_valid", DUMP_VALID, 1);
          check("hold_beat", {DUMP_ADDR, DUMP_DATA}, prev_beat);
        end
        if (DUMP_VALID && DUMP_READY) begin
          log_q.push_back('{a: DUMP_ADDR, d: DUMP_DATA});
          if (m_exp.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL unexpected_beat: got %0h/%0h expected none", DUMP_ADDR, DUMP_DATA);
          end else begin
            check("beat", {DUMP_ADDR, DUMP_DATA}, m_exp.pop_front());
          end
        end
        if (FINISHED && !fin_prev) check("fin_all_beats_sent", m_exp.size(), 0);
        prev_hold = DUMP_VALID && !DUMP_READY;
        prev_beat = '{a: DUMP_ADDR, d: DUMP_DATA};
      end
      fin_prev = FINISHED;
    end
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    OUTADDR = a; OUTDATA = d; OUTVALID = 1'b1;
    tick();
    OUTVALID = 1'b0;
  endtask

  task automatic do_reset(input int n);
    RESET = 1'b1; DONE = 1'b0; OUTVALID = 1'b0;
    repeat (n) tick();
    RESET = 1'b0;
  endtask

  task automatic wait_fin(input string name, input int budget);
    int i = 0;
    while (!FINISHED && i < budget) begin tick(); i++; end
    check(name, FINISHED, 1);
  endtask

  task automatic wait_valid(input string name, input int budget);
    int i = 0;
    while (!DUMP_VALID && i < budget) begin tick(); i++; end
    check(name, DUMP_VALID, 1);
  endtask

  function automatic logic [63:0] all_outs();
    return {1'b0, DUMP_VALID, DUMP_ADDR, DUMP_DATA, FINISHED, WR_COUNT, OVERWRITE_COUNT, LATE_COUNT};
  endfunction

  initial begin
    // 1/2: reset and idle
    do_reset(2);
    check("reset_outputs", all_outs(), 0);
    repeat (20) tick();
    check("idle_outputs", all_outs(), 0);

    // 3: two stores, free-flowing dump
    log_q.delete();
    DUMP_READY = 1'b1;
    store(5'd3, 32'h4);
    store(5'd5, 32'h1);
    DONE = 1'b1;
    wait_fin("t3_finish", 100);
    check("t3_beats", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("t3_beat0", log_q[0], {5'd3, 32'h0000_0004});
      check("t3_beat1", log_q[1], {5'd5, 32'h0000_0001});
    end
    check("t3_wr", WR_COUNT, 2);
    check("t3_ow", OVERWRITE_COUNT, 0);

    // 4: overwrite, last write wins
    do_reset(1);
    log_q.delete();
    store(5'd8, 32'hA);
    store(5'd8, 32'hB);
    DONE = 1'b1;
    wait_fin("t4_finish", 100);
    check("t4_beats", log_q.size(), 1);
    if (log_q.size() == 1) check("t4_beat0", log_q[0], {5'd8, 32'h0000_000B});
    check("t4_ow", OVERWRITE_COUNT, 1);
    check("t4_wr", WR_COUNT, 2);

    // 5: backpressure
    do_reset(1);
    log_q.delete();
    DUMP_READY = 1'b0;
    store(5'd2, 32'h55);
    DONE = 1'b1;
    wait_valid("t5_valid_rise", 60);
    repeat (3) begin
      check("t5_hold_valid", DUMP_VALID, 1);
      check("t5_hold_beat", {DUMP_ADDR, DUMP_DATA}, {5'd2, 32'h55});
      tick();
    end
    DUMP_READY = 1'b1;
    wait_fin("t5_finish", 100);
    check("t5_beats", log_q.size(), 1);

    // 6: store coincident with DONE is captured, the next one is late
    do_reset(1);
    log_q.delete();
    OUTADDR = 5'd4; OUTDATA = 32'h7; OUTVALID = 1'b1; DONE = 1'b1;
    tick();
    OUTADDR = 5'd6; OUTDATA = 32'h9; OUTVALID = 1'b1;
    tick();
    OUTVALID = 1'b0;
    wait_fin("t6_finish", 100);
    check("t6_beats", log_q.size(), 1);
    if (log_q.size() == 1) check("t6_beat0", log_q[0], {5'd4, 32'h7});
    check("t6_late", LATE_COUNT, 1);
    check("t6_wr", WR_COUNT, 1);

    // 7: reset in HOLD, then an empty run with exact finish latency
    do_reset(1);
    DUMP_READY = 1'b0;
    store(5'd1, 32'h11);
    DONE = 1'b1;
    wait_valid("t7_valid_rise", 60);
    tick(); tick();
    check("t7_in_hold", DUMP_VALID, 1);
    RESET = 1'b1; DONE = 1'b0;
    tick();
    RESET = 1'b0;
    check("t7_beat_dropped", DUMP_VALID, 0);
    check("t7_fin_cleared", FINISHED, 0);
    repeat (3) tick();
    log_q.delete();
    DONE = 1'b1;
    for (int j = 0; j <= DEPTH + 1; j++) begin
      tick();
      check("t7_no_valid", DUMP_VALID, 0);
      check("t7_fin_time", FINISHED, (j == DEPTH + 1) ? 1 : 0);
    end
    check("t7_beats", log_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

endmodule
